// File: rtl/obi_instr_responder_if.sv
// Instruction-fetch OBI bus bundle between the core initiator and the responder.
// Carries request/grant address phase and rvalid/rdata/err response phase.
// Signal names keep the responder-side _i/_o direction suffixes.
interface obi_instr_responder_if;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;

  // Responder (memory) side
  modport slave (
    input  obi_req_i,
    input  obi_addr_i,
    input  obi_we_i,
    output obi_gnt_o,
    output obi_rvalid_o,
    output obi_rdata_o,
    output obi_err_o
  );

  // Initiator (core prefetcher) side
  modport master (
    output obi_req_i,
    output obi_addr_i,
    output obi_we_i,
    input  obi_gnt_o,
    input  obi_rvalid_o,
    input  obi_rdata_o,
    input  obi_err_o
  );
endinterface

// File: rtl/obi_instr_responder.sv
// OBI instruction-fetch responder in front of a synchronous single-port SRAM.
// Latency: grant in cycle N -> rvalid in N+1 (fall-through), later when stalled.
// Backpressure: stall_rsp_i parks responses in an in-order FIFO; grants stop at MAX_OUTSTANDING.

// Generic synchronous FIFO, first-word visible on rdat_o while not empty.
// Latency: push visible at the head one cycle later.
// Backpressure: none internally; the caller guarantees no push when full.
module obi_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdat_i,
  input  logic         pop_i,
  output logic [W-1:0] rdat_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdat_i;
  end

  assign rdat_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
endmodule

module obi_instr_responder #(
  parameter int          MEM_AW          = 14,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  obi_instr_responder_if.slave  obi,
  output logic                  mem_req_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  stall_gnt_i,
  input  logic                  stall_rsp_i,
  output logic                  busy_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_v_q, pend_err_q;
  logic          gnt, in_range, good_rd;
  logic [31:0]   addr_off, word_off;
  logic          fifo_empty, fall_through, push, pop, rvalid;
  rsp_t          pend_rsp, head_rsp, out_rsp;

  // Address phase: grant is combinational; a response in this same cycle
  // does not open a slot, so the count alone gates it.
  assign gnt      = obi.obi_req_i & ~stall_gnt_i & (cnt_q < CW'(MAX_OUTSTANDING));
  // Unsigned offset wraps for addresses below the base, so one compare
  // covers both ends of the window. Byte-lane bits drop out in the shift.
  assign addr_off = obi.obi_addr_i - BASE_ADDR;
  assign word_off = addr_off >> 2;
  assign in_range = ((word_off >> MEM_AW) == 32'd0);
  assign good_rd  = ~obi.obi_we_i & in_range;

  assign obi.obi_gnt_o = gnt;
  assign mem_req_o     = gnt & good_rd;
  assign mem_addr_o    = mem_req_o ? word_off[MEM_AW-1:0] : '0;

  // Capture stage: remembers what was granted last cycle so the SRAM data
  // (or a synthesized error) can be paired with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q   <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      pend_v_q   <= gnt;
      pend_err_q <= gnt & ~good_rd;
    end
  end

  assign pend_rsp.rdata = pend_err_q ? 32'h0 : mem_rdata_i;
  assign pend_rsp.err   = pend_err_q;

  // Response path: bypass the FIFO only when nothing older is queued, which
  // keeps responses in request order.
  assign fall_through = fifo_empty & pend_v_q & ~stall_rsp_i;
  assign push         = pend_v_q & ~fall_through;
  assign pop          = ~fifo_empty & ~stall_rsp_i;
  assign rvalid       = fall_through | pop;

  obi_rsp_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdat_i  (pend_rsp),
    .pop_i   (pop),
    .rdat_o  (head_rsp),
    .empty_o (fifo_empty)
  );

  // Output mux; data and err are forced to zero between responses.
  always_comb begin
    out_rsp = '0;
    if (rvalid) out_rsp = fifo_empty ? pend_rsp : head_rsp;
  end

  assign obi.obi_rvalid_o = rvalid;
  assign obi.obi_rdata_o  = out_rsp.rdata;
  assign obi.obi_err_o    = out_rsp.err;

  // Outstanding counter: +1 per grant, -1 per response.
  always_comb begin
    cnt_d = cnt_q + CW'(gnt) - CW'(rvalid);
  end

  // Counter register; transactions in flight at reset are simply forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
endmodule

// File: tb/tb_obi_instr_responder.sv
module tb_obi_instr_responder;
  localparam int          MEM_AW = 14;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          MAXO   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_req_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_rdata_i = 32'hDEAD_BEEF;
  logic              stall_gnt_i = 1'b0;
  logic              stall_rsp_i = 1'b0;
  logic              busy_o;

  obi_instr_responder_if bus();

  obi_instr_responder #(
    .MEM_AW          (MEM_AW),
    .BASE_ADDR       (BASE),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .obi         (bus),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .stall_gnt_i (stall_gnt_i),
    .stall_rsp_i (stall_rsp_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: data appears the cycle after the read strobe.
  logic [31:0] sram [2**MEM_AW];
  always @(posedge clk) if (mem_req_o) mem_rdata_i <= sram[mem_addr_o];

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: responses still owed, oldest first. A grant made in the
  // current cycle is staged and only becomes eligible from the next cycle.
  logic [32:0] exp_q[$];
  logic        stage_v = 1'b0;
  logic [32:0] stage_d = '0;
  logic        mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: {rdata, err} for an access, from the memory map alone.
  function automatic logic [32:0] ref_rsp(input logic [31:0] a, input logic we);
    logic [31:0] off;
    off = a - BASE;
    if (we || off >= 32'(4 * (2**MEM_AW))) return {32'h0, 1'b1};
    return {32'hA000_0000 + (off >> 2), 1'b0};
  endfunction

  // One bus cycle of stimulus plus address-phase checks.
  task automatic step(input logic req, input logic [31:0] addr, input logic we,
                      input logic sg, input logic sr);
    logic        exp_g;
    logic [32:0] r;
    @(negedge clk);
    bus.obi_req_i  = req;
    bus.obi_addr_i = addr;
    bus.obi_we_i   = we;
    stall_gnt_i    = sg;
    stall_rsp_i    = sr;
    #1;
    exp_g = req & ~sg & (exp_q.size() < MAXO);
    r     = ref_rsp(addr, we);
    chk("gnt", bus.obi_gnt_o, exp_g);
    chk("busy", busy_o, exp_q.size() != 0);
    chk("mem_req", mem_req_o, exp_g & ~r[0]);
    if (exp_g & ~r[0]) chk("mem_addr", mem_addr_o, (addr - BASE) >> 2);
    if (bus.obi_gnt_o) begin
      stage_v = 1'b1;
      stage_d = r;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || stage_v) && k < 40) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rvalid"}, bus.obi_rvalid_o, 1'b0);
    chk({tag, "_rdata"}, bus.obi_rdata_o, 32'h0);
    chk({tag, "_err"}, bus.obi_err_o, 1'b0);
    chk({tag, "_mem_req"}, mem_req_o, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_gnt"}, bus.obi_gnt_o, 1'b0);
  endtask

  // Response monitor: decoupled from the driver, runs after inputs settle.
  always @(negedge clk) begin : monitor
    logic        ev;
    logic [32:0] r;
    if (mon_en) begin
      #2;
      ev = !stall_rsp_i && (exp_q.size() > 0);
      chk("rvalid", bus.obi_rvalid_o, ev);
      if (bus.obi_rvalid_o && ev) begin
        r = exp_q.pop_front();
        chk("rdata", bus.obi_rdata_o, r[32:1]);
        chk("err", bus.obi_err_o, r[0]);
      end else if (!bus.obi_rvalid_o) begin
        chk("idle_rdata", bus.obi_rdata_o, 32'h0);
        chk("idle_err", bus.obi_err_o, 1'b0);
      end
      if (stage_v) begin
        exp_q.push_back(stage_d);
        stage_v = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 2**MEM_AW; i++) sram[i] = 32'hA000_0000 + i;
    bus.obi_req_i  = 1'b0;
    bus.obi_addr_i = 32'h0;
    bus.obi_we_i   = 1'b0;

    // Reset state
    #1;
    chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Back-to-back reads
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    drain();

    // Response stall: only MAXO grants, then in-order release
    for (int i = 0; i < 5; i++) step(1'b1, 32'(32'h100 + i * 4), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h200 + i * 4), 1'b0, 1'b0, 1'b0);
    drain();

    // Errors: out of range read, write, then a good read
    step(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    drain();

    // Ordering mix with toggling response stall
    step(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0307, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'(i % 2 == 0));
    drain();

    // Grant stall
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 8 == 0) a = $urandom | 32'h0001_0000;
      else                   a = $urandom_range(0, 2**(MEM_AW + 2) - 1);
      step(1'($urandom % 4 != 0), a, 1'($urandom % 10 == 0),
           1'($urandom % 5 == 0), 1'($urandom % 4 == 0));
    end
    drain();

    // Reset with two transactions outstanding
    step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    exp_q.delete();
    stage_v = 1'b0;
    @(posedge clk);
    #1;
    stall_rsp_i = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 32'h0000_0048, 1'b0, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end
endmodule
